seg_scan_controller: RTL and testbench

- Time-multiplexes one 3-bit-to-7-segment decoder across NUM_DIGITS digit positions of a common-segment display.
- Holds a double-buffered bank of 3-bit digit codes and presents one code at a time on code_out, which feeds the decoder input.
- Drives a one-hot digit enable, with a blanking gap between digits to prevent ghosting.
- Sits between the user logic that writes codes and the decoder/display pins.

---
 rtl/seg_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Scan controller for a multiplexed common-segment display: one shared 3-bit decoder,
// one-hot digit enables with a dark gap before each slot, double-buffered code bank.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [3*NUM_DIGITS-1:0] codes,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [2:0]              code_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int unsigned CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [3*NUM_DIGITS-1:0] active, active_n;
  logic [3*NUM_DIGITS-1:0] pending, pending_n;
  logic                    pend_valid, pend_valid_n;
  logic [2:0]              code_n;
  logic [NUM_DIGITS-1:0]   digit_en_n;
  logic                    frame_done_n;
  logic                    busy_n;
  logic                    wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      code_out   <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      active     <= active_n;
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
      code_out   <= code_n;
      digit_en   <= digit_en_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    active_n     = active;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    code_n       = code_out;
    digit_en_n   = '0;
    frame_done_n = 1'b0;
    busy_n       = 1'b0;

    wrap = (state == SHOW) && enable && (cnt == P_LAST) && (idx == I_LAST);

    case (state)
      IDLE: begin
        if (enable) begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt == B_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt == P_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = (idx == I_LAST) ? '0 : idx + IW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase

    // Active bank only moves while idle or on the frame wrap; a load on the wrap beats pending.
    if (state == IDLE) begin
      if (load) begin
        active_n     = codes;
        pend_valid_n = 1'b0;
      end
    end else if (wrap) begin
      if (load) begin
        active_n     = codes;
        pend_valid_n = 1'b0;
      end else if (pend_valid) begin
        active_n     = pending;
        pend_valid_n = 1'b0;
      end
    end else if (load) begin
      pending_n    = codes;
      pend_valid_n = 1'b1;
    end

    // Code is presented on entry to BLANK so the decoder settles while dark.
    if ((state_n == BLANK) && (state != BLANK)) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_n == IW'(i)) code_n = active_n[3*i +: 3];
      end
    end

    if (state_n == SHOW) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        digit_en_n[i] = (idx_n == IW'(i)) && !blank_mask[i];
      end
    end

    frame_done_n = (state_n == SHOW) && (cnt_n == P_LAST) && (idx_n == I_LAST);
    busy_n       = (state_n != IDLE);
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: frame-timer reference model checked every cycle,
// plus directed literal checks at hand-computed cycle offsets.
module tb_seg_scan_controller;
  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 2;
  localparam int D = B + P;
  localparam int F = N * D;

  logic           clk = 1'b0;
  logic           reset, enable, load;
  logic [3*N-1:0] codes;
  logic [N-1:0]   blank_mask;
  logic [2:0]     code_out;
  logic [N-1:0]   digit_en;
  logic           frame_done, busy;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS(N),
    .PRESCALE(P),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .codes(codes),
    .load(load),
    .blank_mask(blank_mask),
    .code_out(code_out),
    .digit_en(digit_en),
    .frame_done(frame_done),
    .busy(busy)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  // Reference model: a frame timer m_t (0..F-1) from which slot/phase follow arithmetically.
  bit             m_run = 1'b0;
  int             m_t   = 0;
  logic [3*N-1:0] m_act = '0, m_pend = '0;
  bit             m_pv  = 1'b0;
  logic [2:0]     m_code = '0;
  logic [N-1:0]   m_den = '0;
  logic           m_fd = 1'b0, m_busy = 1'b0;

  function automatic logic [2:0] dig_code(logic [3*N-1:0] bank, int d);
    return bank[3*d +: 3];
  endfunction

  task automatic model_step();
    bit wrap;
    int ph, dg;
    if (reset) begin
      m_run = 0; m_t = 0; m_act = '0; m_pend = '0; m_pv = 0;
      m_code = '0; m_den = '0; m_fd = 0; m_busy = 0;
    end else begin
      wrap = m_run && enable && (m_t == F - 1);
      if (!m_run) begin
        if (load) begin m_act = codes; m_pv = 0; end
      end else if (wrap) begin
        if (load) begin m_act = codes; m_pv = 0; end
        else if (m_pv) begin m_act = m_pend; m_pv = 0; end
      end else if (load) begin
        m_pend = codes; m_pv = 1;
      end
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_t = 0; m_code = dig_code(m_act, 0);
        end
      end else if (!enable) begin
        m_run = 0; m_t = 0;
      end else begin
        m_t = (m_t + 1) % F;
        if (m_t % D == 0) m_code = dig_code(m_act, m_t / D);
      end
      if (m_run) begin
        ph = m_t % D;
        dg = m_t / D;
        m_den  = (ph >= B && !blank_mask[dg]) ? N'(1 << dg) : '0;
        m_fd   = (m_t == F - 1);
        m_busy = 1'b1;
      end else begin
        m_den = '0; m_fd = 0; m_busy = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, got, want);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_code_out", 32'(code_out), 32'(m_code));
      check("model_digit_en", 32'(digit_en), 32'(m_den));
      check("model_frame_done", 32'(frame_done), 32'(m_fd));
      check("model_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic goto(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; codes = '0; blank_mask = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_code", 32'(code_out), 32'h0);
    check("rst_den", 32'(digit_en), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    reset = 1'b0; load = 1'b1; codes = 12'b111_110_001_000;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    cyc = 0;

    goto(1);  check("f1_blank_den", 32'(digit_en), 32'h0);
              check("f1_blank_code", 32'(code_out), 32'h0);
              check("f1_busy", 32'(busy), 32'h1);
    goto(3);  check("f1_d0_den", 32'(digit_en), 32'h1);
    goto(9);  check("f1_d1_den", 32'(digit_en), 32'h2);
              check("f1_d1_code", 32'(code_out), 32'h1);
    goto(15); check("f1_d2_den", 32'(digit_en), 32'h4);
              check("f1_d2_code", 32'(code_out), 32'h6);
    goto(21); check("f1_d3_den", 32'(digit_en), 32'h8);
              check("f1_d3_code", 32'(code_out), 32'h7);
    goto(23); check("f1_fd_early", 32'(frame_done), 32'h0);
    goto(24); check("f1_fd", 32'(frame_done), 32'h1);
    goto(25); check("f1_fd_after", 32'(frame_done), 32'h0);
              check("f2_code0", 32'(code_out), 32'h0);

    goto(33); codes = 12'o7777; load = 1'b1;
    goto(34); load = 1'b0;
    goto(39); check("f2_d2_den", 32'(digit_en), 32'h4);
              check("f2_d2_code_old", 32'(code_out), 32'h6);
    goto(45); check("f2_d3_code_old", 32'(code_out), 32'h7);
    goto(51); check("f3_d0_code_new", 32'(code_out), 32'h7);
              check("f3_d0_den", 32'(digit_en), 32'h1);

    goto(52); codes = 12'o1111; load = 1'b1;
    goto(53); load = 1'b0;
    goto(60); codes = 12'o2222; load = 1'b1;
    goto(61); load = 1'b0;
    goto(75); check("f4_latest_wins", 32'(code_out), 32'h2);
              check("f4_d0_den", 32'(digit_en), 32'h1);

    goto(80); codes = 12'o1111; load = 1'b1;
    goto(81); load = 1'b0;
    goto(96); check("f4_fd", 32'(frame_done), 32'h1);
              codes = 12'o3333; load = 1'b1;
    goto(97); load = 1'b0;
              check("f5_wrap_load", 32'(code_out), 32'h3);
              blank_mask = 4'b0100;
    goto(111); check("f5_masked_den", 32'(digit_en), 32'h0);
               check("f5_masked_code", 32'(code_out), 32'h3);
    goto(117); check("f5_d3_den", 32'(digit_en), 32'h8);
    goto(120); check("f5_fd", 32'(frame_done), 32'h1);
    goto(121); blank_mask = '0;

    goto(135); check("f6_d2_den", 32'(digit_en), 32'h4);
    goto(136); enable = 1'b0;
    goto(137); check("drop_den", 32'(digit_en), 32'h0);
               check("drop_busy", 32'(busy), 32'h0);
               check("drop_fd", 32'(frame_done), 32'h0);
    goto(140); enable = 1'b1;
    goto(141); check("reen_busy", 32'(busy), 32'h1);
               check("reen_den", 32'(digit_en), 32'h0);
               check("reen_code", 32'(code_out), 32'h3);
    goto(143); check("reen_d0_den", 32'(digit_en), 32'h1);

    goto(145); reset = 1'b1;
    goto(146); check("mid_rst_code", 32'(code_out), 32'h0);
               check("mid_rst_den", 32'(digit_en), 32'h0);
               check("mid_rst_busy", 32'(busy), 32'h0);
               check("mid_rst_fd", 32'(frame_done), 32'h0);
               reset = 1'b0;
    goto(147); check("post_rst_busy", 32'(busy), 32'h1);
               check("post_rst_code", 32'(code_out), 32'h0);
    goto(149); check("post_rst_d0_den", 32'(digit_en), 32'h1);
    goto(167); check("post_rst_d3_den", 32'(digit_en), 32'h8);
               check("post_rst_d3_code", 32'(code_out), 32'h0);
    goto(170); check("post_rst_fd", 32'(frame_done), 32'h1);
    goto(172);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
